// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR ping-pong input buffer.
// Bank depth must equal 2**ADDR_W so the address counters wrap naturally.
package fir_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int FCNT_W = 16;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fir_rd_sequencer.sv
// Read side of the ping-pong buffer: walks a full bank from address 0 to DEPTH-1
// and carries valid/last/bank through the RAM read latency to the FIR engine.
module fir_rd_sequencer
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_full,
    input  logic [DATA_W-1:0] i_mem0_data,
    input  logic [DATA_W-1:0] i_mem1_data,
    output logic              o_rd_state,
    output logic              o_rd_done,
    output logic              o_rd_bank,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic [DATA_W-1:0] o_proc_data,
    output logic              o_proc_vld,
    output logic              o_proc_last,
    output logic              o_proc_bank
);

    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic              r_s1_vld;
    logic              r_s1_last;
    logic              r_s1_bank;
    logic [DATA_W-1:0] r_proc_data;
    logic              r_proc_vld;
    logic              r_proc_last;
    logic              r_proc_bank;

    logic              w_at_last;
    logic              w_other_bank;
    logic              w_rd_active;
    logic              w_rd_done;

    assign w_at_last    = (r_rd_addr == LAST_ADDR);
    assign w_other_bank = ~r_rd_bank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A full partner bank at the last address keeps the stream going without a bubble.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            R_IDLE: begin
                if (i_full[r_rd_bank]) begin
                    w_next_state = R_READ;
                end
            end
            R_READ: begin
                if (w_at_last && !i_full[w_other_bank]) begin
                    w_next_state = R_IDLE;
                end
            end
            default: w_next_state = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_active = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            R_READ: begin
                w_rd_active = 1'b1;
                w_rd_done   = w_at_last;
            end
            default: begin
                w_rd_active = 1'b0;
                w_rd_done   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_frame_cnt <= '0;
        end else if (w_rd_done) begin
            r_rd_bank   <= w_other_bank;
            r_rd_addr   <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end else if (w_rd_active) begin
            r_rd_addr   <= r_rd_addr + 1'b1;
        end
    end

    // Stage 1 lines up with RAM read data, stage 2 is the registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_bank   <= 1'b0;
            r_proc_vld  <= 1'b0;
            r_proc_last <= 1'b0;
            r_proc_bank <= 1'b0;
            r_proc_data <= '0;
        end else begin
            r_s1_vld    <= w_rd_active;
            r_s1_last   <= w_rd_done;
            r_s1_bank   <= r_rd_bank;
            r_proc_vld  <= r_s1_vld;
            r_proc_last <= r_s1_last;
            r_proc_bank <= r_s1_bank;
            if (r_s1_vld) begin
                r_proc_data <= r_s1_bank ? i_mem1_data : i_mem0_data;
            end
        end
    end

    assign o_rd_state  = (r_state == R_READ);
    assign o_rd_done   = w_rd_done;
    assign o_rd_bank   = r_rd_bank;
    assign o_rd_addr   = r_rd_addr;
    assign o_frame_cnt = r_frame_cnt;
    assign o_proc_data = r_proc_data;
    assign o_proc_vld  = r_proc_vld;
    assign o_proc_last = r_proc_last;
    assign o_proc_bank = r_proc_bank;

endmodule

// File: rtl/fir_pingpong_ctrl.sv
// Ping-pong controller for the FIR input path: fills one RAM bank with incoming
// samples while the other, full bank streams to the MAC engine.
module fir_pingpong_ctrl
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_vld,
    output logic              in_data_rdy,
    output logic [DATA_W-1:0] mem0_in_data,
    output logic              mem0_we_wr,
    output logic [ADDR_W-1:0] mem0_addr_wr,
    output logic [ADDR_W-1:0] mem0_addr_rd,
    output logic              mem0_we_rd,
    input  logic [DATA_W-1:0] mem0_out_data,
    output logic [DATA_W-1:0] mem1_in_data,
    output logic              mem1_we_wr,
    output logic [ADDR_W-1:0] mem1_addr_wr,
    output logic [ADDR_W-1:0] mem1_addr_rd,
    output logic              mem1_we_rd,
    input  logic [DATA_W-1:0] mem1_out_data,
    output logic [DATA_W-1:0] proc_data,
    output logic              proc_data_vld,
    output logic              proc_last,
    output logic              proc_bank,
    output logic              ovf_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [1:0]        r_full;
    logic              r_ovf;
    logic [1:0]        r_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_rdy;
    logic              w_accept;
    logic              w_wr_wrap;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;
    logic              w_rd_state;
    logic              w_rd_done;
    logic              w_rd_bank;
    logic [ADDR_W-1:0] w_rd_addr;

    // Held low during reset so every output reads 0 while reset is asserted.
    assign w_rdy     = reset & ~r_full[r_wr_bank];
    assign w_accept  = in_data_vld & w_rdy;
    assign w_wr_wrap = w_accept & (r_wr_ptr == LAST_ADDR);
    assign w_set     = w_wr_wrap ? bank_onehot(r_wr_bank) : 2'b00;
    assign w_clr     = w_rd_done ? bank_onehot(w_rd_bank) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
            r_we      <= 2'b00;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_we <= w_accept ? bank_onehot(r_wr_bank) : 2'b00;
            if (w_accept) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= in_data;
                r_wr_ptr  <= w_wr_wrap ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_wr_wrap) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Set and clear never target the same bank: a full bank cannot be written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 2'b00;
            r_ovf  <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (in_data_vld && !w_rdy) begin
                r_ovf <= 1'b1;
            end
        end
    end

    fir_rd_sequencer u_rd_seq (
        .clk         (clk),
        .reset       (reset),
        .i_full      (r_full),
        .i_mem0_data (mem0_out_data),
        .i_mem1_data (mem1_out_data),
        .o_rd_state  (w_rd_state),
        .o_rd_done   (w_rd_done),
        .o_rd_bank   (w_rd_bank),
        .o_rd_addr   (w_rd_addr),
        .o_frame_cnt (frame_cnt),
        .o_proc_data (proc_data),
        .o_proc_vld  (proc_data_vld),
        .o_proc_last (proc_last),
        .o_proc_bank (proc_bank)
    );

    assign in_data_rdy  = w_rdy;
    assign ovf_err      = r_ovf;

    assign mem0_in_data = r_wr_data;
    assign mem0_we_wr   = r_we[0];
    assign mem0_addr_wr = r_wr_addr;
    assign mem0_addr_rd = (w_rd_state && !w_rd_bank) ? w_rd_addr : '0;
    assign mem0_we_rd   = 1'b0;

    assign mem1_in_data = r_wr_data;
    assign mem1_we_wr   = r_we[1];
    assign mem1_addr_wr = r_wr_addr;
    assign mem1_addr_rd = (w_rd_state && w_rd_bank) ? w_rd_addr : '0;
    assign mem1_we_rd   = 1'b0;

endmodule

// File: tb/tb_fir_pingpong_ctrl.sv
// Bench for the FIR ping-pong controller: two behavioural RAM banks, a sample
// scoreboard indexed by acceptance order, and directed plus random traffic.
module tb_fir_pingpong_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_data_vld = 1'b0;
  logic          in_data_rdy;
  logic [DW-1:0] mem0_in_data, mem1_in_data;
  logic          mem0_we_wr, mem1_we_wr;
  logic [AW-1:0] mem0_addr_wr, mem1_addr_wr;
  logic [AW-1:0] mem0_addr_rd, mem1_addr_rd;
  logic          mem0_we_rd, mem1_we_rd;
  logic [DW-1:0] mem0_out_data, mem1_out_data;
  logic [DW-1:0] proc_data;
  logic          proc_data_vld, proc_last, proc_bank, ovf_err;
  logic [15:0]   frame_cnt;

  fir_pingpong_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_data_vld   (in_data_vld),
    .in_data_rdy   (in_data_rdy),
    .mem0_in_data  (mem0_in_data),
    .mem0_we_wr    (mem0_we_wr),
    .mem0_addr_wr  (mem0_addr_wr),
    .mem0_addr_rd  (mem0_addr_rd),
    .mem0_we_rd    (mem0_we_rd),
    .mem0_out_data (mem0_out_data),
    .mem1_in_data  (mem1_in_data),
    .mem1_we_wr    (mem1_we_wr),
    .mem1_addr_wr  (mem1_addr_wr),
    .mem1_addr_rd  (mem1_addr_rd),
    .mem1_we_rd    (mem1_we_rd),
    .mem1_out_data (mem1_out_data),
    .proc_data     (proc_data),
    .proc_data_vld (proc_data_vld),
    .proc_last     (proc_last),
    .proc_bank     (proc_bank),
    .ovf_err       (ovf_err),
    .frame_cnt     (frame_cnt)
  );

  // ---------------- clock / reset / RAM models ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram0 [DEPTH];
  logic [DW-1:0] ram1 [DEPTH];
  always @(posedge clk) begin
    if (mem0_we_wr) ram0[mem0_addr_wr] <= mem0_in_data;
    if (mem1_we_wr) ram1[mem1_addr_wr] <= mem1_in_data;
    mem0_out_data <= ram0[mem0_addr_rd];
    mem1_out_data <= ram1[mem1_addr_rd];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } wr_t;

  typedef struct packed {
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
  } hist_t;

  logic [DW-1:0] exp_q[$];
  wr_t           wr_q[$];
  int            n_acc, n_wr, n_proc;
  int            t_last_wr, t_first_vld, t_first_last;
  logic          prev_vld, prev_last;
  hist_t         h1, h2;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    wr_q.delete();
    n_acc = 0; n_wr = 0; n_proc = 0;
    t_last_wr = -1; t_first_vld = -1; t_first_last = -1;
    prev_vld = 1'b0; prev_last = 1'b0;
    h1 = '0; h2 = '0;
  endtask

  // Samples are stored in acceptance order; sample n lives in bank (n/DEPTH)%2 at n%DEPTH.
  task automatic monitor();
    hist_t cur;
    check("we_rd", {mem1_we_rd, mem0_we_rd}, 0);
    if (mem0_we_wr || mem1_we_wr) begin
      if (wr_q.size() == 0) begin
        check("wr_spurious", {mem1_we_wr, mem0_we_wr}, 0);
      end else begin
        wr_t w;
        int  b;
        w = wr_q.pop_front();
        b = (n_wr / DEPTH) % 2;
        check("wr_we", {mem1_we_wr, mem0_we_wr}, (b == 1) ? 2 : 1);
        check("wr_addr", (b == 1) ? mem1_addr_wr : mem0_addr_wr, n_wr % DEPTH);
        check("wr_data", (b == 1) ? mem1_in_data : mem0_in_data, w.data);
        check("wr_lat", cyc - w.t, 1);
        if ((n_wr % DEPTH) == DEPTH - 1 && t_last_wr < 0) t_last_wr = cyc;
        n_wr++;
      end
    end
    if (prev_vld && !prev_last) check("gap", proc_data_vld, 1);
    if (proc_data_vld) begin
      if (exp_q.size() == 0) begin
        check("rd_spurious", proc_data_vld, 0);
      end else begin
        logic [DW-1:0] e;
        logic [AW-1:0] ra, wa;
        logic          wen;
        int            b, k;
        e = exp_q.pop_front();
        b = (n_proc / DEPTH) % 2;
        k = n_proc % DEPTH;
        ra  = (b == 1) ? h2.ra1 : h2.ra0;
        wa  = (b == 1) ? h2.wa1 : h2.wa0;
        wen = h2.we[b];
        check("proc_data", proc_data, e);
        check("proc_bank", proc_bank, b);
        check("proc_last", proc_last, (k == DEPTH - 1) ? 1 : 0);
        check("rd_addr", ra, k);
        check("rw_collide", wen && (wa == ra), 0);
        if (t_first_vld < 0) t_first_vld = cyc;
        if (proc_last && t_first_last < 0) t_first_last = cyc;
        n_proc++;
      end
    end
    cur.we  = {mem1_we_wr, mem0_we_wr};
    cur.wa0 = mem0_addr_wr;
    cur.wa1 = mem1_addr_wr;
    cur.ra0 = mem0_addr_rd;
    cur.ra1 = mem1_addr_rd;
    h2 = h1;
    h1 = cur;
    prev_vld  = proc_data_vld;
    prev_last = proc_last;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (reset) monitor();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d);
    in_data_vld = v;
    in_data     = d;
    if (v && in_data_rdy) begin
      exp_q.push_back(d);
      wr_q.push_back('{data: d, t: cyc});
      n_acc++;
    end
  endtask

  // mode 0: vld every cycle, 1: vld follows rdy, 2: vld every other cycle, 3: random vld when rdy
  task automatic send(input int n, input int mode, input logic seq);
    int            sent = 0;
    int            guard = 0;
    logic          v;
    logic [DW-1:0] d;
    while (sent < n && guard < 2000) begin
      tick();
      d = seq ? DW'(sent + 1) : DW'($urandom_range(0, 255));
      case (mode)
        0:       v = 1'b1;
        1:       v = in_data_rdy;
        2:       v = (guard % 2 == 0);
        default: v = in_data_rdy && ($urandom_range(0, 3) != 0);
      endcase
      if (v && in_data_rdy) sent++;
      drive(v, d);
      guard++;
    end
    tick();
    drive(1'b0, '0);
    if (sent < n) check("send_timeout", sent, n);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || proc_data_vld) && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) check("drain_timeout", exp_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_ctl", tag),
          {in_data_rdy, ovf_err, proc_data_vld, proc_last, proc_bank, proc_data, frame_cnt}, 0);
    check($sformatf("%s_addr", tag),
          {mem0_we_wr, mem1_we_wr, mem0_addr_wr, mem1_addr_wr, mem0_addr_rd, mem1_addr_rd}, 0);
    check($sformatf("%s_wdata", tag), {mem0_in_data, mem1_in_data}, 0);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    in_data_vld = 1'b0;
    in_data     = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    clear_model();
    reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_model();
    do_reset();

    // 1: one frame of 1..16
    send(16, 0, 1'b1);
    drain();
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_lat_vld", t_first_vld - t_last_wr, 3);
    check("t1_lat_last", t_first_last - t_last_wr, 3 + DEPTH - 1);
    check("t1_ovf", ovf_err, 0);

    // 2: three frames, source honours rdy
    do_reset();
    send(48, 1, 1'b0);
    drain();
    check("t2_frame_cnt", frame_cnt, 3);
    check("t2_words", n_proc, 48);
    check("t2_ovf", ovf_err, 0);

    // 3: fill both banks, then offer a sample while full
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick();
      drive(1'b1, DW'($urandom_range(0, 255)));
    end
    tick();
    check("t3_rdy_low", in_data_rdy, 0);
    drive(1'b1, 8'hA5);
    tick();
    check("t3_ovf_set", ovf_err, 1);
    check("t3_rdy_back", in_data_rdy, 1);
    drive(1'b0, '0);
    drain();
    check("t3_ovf_held", ovf_err, 1);
    check("t3_frame_cnt", frame_cnt, 2);
    check("t3_words", n_proc, 32);

    // 4: vld every other cycle
    do_reset();
    send(16, 2, 1'b0);
    drain();
    check("t4_lat_vld", t_first_vld - t_last_wr, 3);
    check("t4_frame_cnt", frame_cnt, 1);

    // 5: asynchronous reset in the middle of a drained frame
    do_reset();
    send(16, 0, 1'b0);
    for (int g = 0; g < 100 && n_proc < 8; g++) tick();
    if (n_proc < 8) check("t5_wait", n_proc, 8);
    #1 reset = 1'b0;
    #1 check_zero("t5_async");
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b1;
    send(16, 0, 1'b1);
    drain();
    check("t5_words", n_proc, 16);
    check("t5_frame_cnt", frame_cnt, 1);

    // 6: random traffic over several frames
    do_reset();
    send(80, 3, 1'b0);
    drain();
    check("t6_frame_cnt", frame_cnt, 5);
    check("t6_words", n_proc, 80);
    check("t6_ovf", ovf_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
